// File: rtl/x_mod_53_seq.sv
// Sequential residue unit: reduces an XW-bit operand modulo MOD.
// One 6-bit Horner digit is consumed per clock, MSB digit first.
module x_mod_53_seq #(
  parameter int unsigned XW  = 200,
  parameter int unsigned MOD = 53
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] X,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    R,
  output logic          busy
);

  localparam int unsigned NDIG = (XW + 5) / 6;
  localparam int unsigned EW   = 6 * NDIG;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [11:0] K    = 12'(64 % MOD);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [5:0]      acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   op_q, op_d;
  logic [5:0]      r_q, r_d;

  logic [EW-1:0]   ext;
  logic [11:0]     f;
  logic [6:0]      s0, s1, s2;
  logic [5:0]      acc_new;

  // Replace the upper bits by their weight mod MOD: hi*64 + lo == hi*K + lo.
  function automatic logic [11:0] fold(input logic [11:0] v);
    return v[11:6] * K + {6'd0, v[5:0]};
  endfunction

  always_comb begin
    ext          = '0;
    ext[XW-1:0]  = X;
  end

  // Five folds bring any step value below 95 (< 3*MOD); two subtracts finish it.
  always_comb begin
    f = {6'd0, acc_q} * K + {6'd0, op_q[EW-1 -: 6]};
    for (int i = 0; i < 5; i++) begin
      f = fold(f);
    end
    s0      = 7'(f);
    s1      = (s0 >= 7'(MOD)) ? s0 - 7'(MOD) : s0;
    s2      = (s1 >= 7'(MOD)) ? s1 - 7'(MOD) : s1;
    acc_new = 6'(s2);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    r_d     = r_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = ext;
          acc_d   = '0;
          cnt_d   = CW'(NDIG - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = acc_new;
        op_d  = op_q << 6;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          r_d     = acc_new;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      r_q     <= r_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StBusy) || (state_q == StDone);
  assign R         = r_q;

endmodule

// File: tb/tb_x_mod_53_seq.sv
// Directed bench for x_mod_53_seq: default instance plus a small XW=8/MOD=61 instance.
module tb_x_mod_53_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [199:0] X;
  logic [5:0]   R;

  logic         in2_valid, in2_ready, out2_valid, out2_ready, busy2;
  logic [7:0]   X2;
  logic [5:0]   R2;

  int n_total;
  int n_bad;

  x_mod_53_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .busy      (busy)
  );

  x_mod_53_seq #(.XW(8), .MOD(61)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in2_valid),
    .in_ready  (in2_ready),
    .X         (X2),
    .out_valid (out2_valid),
    .out_ready (out2_ready),
    .R         (R2),
    .busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [199:0] x);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    X        = x;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic wait_result(input string tag, input logic [5:0] exp, input bit scramble);
    int n;
    bit rdy_seen;
    n        = 0;
    rdy_seen = 1'b0;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      if (scramble) X = {$urandom(), $urandom(), $urandom(), $urandom(),
                         $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd34);
    check({tag, "_rdy_busy"}, 64'(rdy_seen), 64'd0);
    check({tag, "_r"}, 64'(R), 64'(exp));
  endtask

  task automatic ack();
    @(negedge clk);
    check("ack_valid_low", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [223:0] wide;
    logic [199:0] xr;
    int           n;
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    X          = '0;
    in2_valid  = 1'b0;
    out2_ready = 1'b1;
    X2         = '0;

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_r", 64'(R), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    accept(200'd0);   wait_result("x0", 6'd0, 1'b0);  ack();
    accept(200'd53);  wait_result("x53", 6'd0, 1'b0); ack();
    accept(200'd52);  wait_result("x52", 6'd52, 1'b0); ack();
    accept(200'd64);  wait_result("x64", 6'd11, 1'b0); ack();
    accept(200'd1);   wait_result("x1", 6'd1, 1'b0);  ack();
    accept({200{1'b1}}); wait_result("ones", 6'd46, 1'b0); ack();

    // Back-pressure: result must hold and new operands must be refused.
    out_ready = 1'b0;
    accept({200{1'b1}});
    wait_result("hold", 6'd46, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      X        = 200'd5;
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_r", 64'(R), 64'd46);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", 64'(out_valid), 64'd0);
    check("hold_release_ready", 64'(in_ready), 64'd1);
    accept(200'd5); wait_result("x5", 6'd5, 1'b0); ack();

    // Operand changes while busy must not disturb the captured copy.
    accept(200'd106); wait_result("scramble", 6'd0, 1'b1); ack();

    // Reset in the middle of a job.
    accept(200'h123456789);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_r", 64'(R), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    accept(200'd54); wait_result("x54", 6'd1, 1'b0); ack();

    for (int i = 0; i < 500; i++) begin
      wide = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom()};
      xr   = wide[199:0];
      accept(xr);
      wait_result("rand", 6'(xr % 200'd53), 1'b0);
      ack();
    end

    // Narrow instance: XW=8, MOD=61, two digits.
    @(negedge clk);
    check("small_in_ready", 64'(in2_ready), 64'd1);
    in2_valid = 1'b1;
    X2        = 8'd255;
    @(negedge clk);
    in2_valid = 1'b0;
    n = 0;
    while (!out2_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("small_lat", 64'(n), 64'd2);
    check("small_r", 64'(R2), 64'd11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
